instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/instr_store.sv | 23 ++
 rtl/instr_sequencer.sv | 147 ++++++++++++++
 tb/tb_instr_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared sequencer definitions: FSM state encodings and the opcode field layout.
// Opcode occupies the top OPC_W bits of every instruction word.
package cpu_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;
  localparam logic [OPC_W-1:0] OPC_JMP  = 4'hE;

  function automatic logic is_busy(input logic [2:0] st);
    return !(st == ST_IDLE || st == ST_HALTED);
  endfunction

endpackage

// File: rtl/instr_store.sv
// Program store: synchronous write port, registered read port (1-cycle latency).
// Contents are deliberately not reset.
module instr_store #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_BITS-1:0]   wr_addr,
  input  logic [INSTR_WIDTH-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [ADDR_BITS-1:0]   rd_addr,
  output logic [INSTR_WIDTH-1:0] rd_data
);

  logic [INSTR_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches words from instr_store and holds each on the
// output for ISSUE_CYCLES cycles. Optional SEQ_SINGLE_STEP_EN adds step/step_mode.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH  = 20,
  parameter int ADDR_BITS    = 5,
  parameter int ISSUE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [ADDR_BITS-1:0]   load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   stop,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                   step,
  input  logic                   step_mode,
`endif
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   busy,
  output logic                   done
);

  // The window is ISSUE + HOLD cycles + the next FETCH, so HOLD lasts
  // ISSUE_CYCLES-2 cycles; with ISSUE_CYCLES==2 the boundary falls in ISSUE.
  localparam logic [3:0] CNT_LOAD = 4'((ISSUE_CYCLES > 2) ? ISSUE_CYCLES - 2 : 1);

  logic [2:0]             state;
  logic [ADDR_BITS-1:0]   pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic [3:0]             cnt;
  logic                   stop_q;

  logic                   wr_en;
  logic                   rd_en;
  logic                   boundary;
  logic                   step_ok;
  logic                   stop_hit;
  logic                   advance;
  logic [OPC_W-1:0]       opcode;
  logic [2:0]             adv_state;
  logic [ADDR_BITS-1:0]   adv_pc;

  instr_store #(
    .INSTR_WIDTH(INSTR_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_store (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(load_addr),
    .wr_data(load_data),
    .rd_en  (rd_en),
    .rd_addr(pc_q),
    .rd_data(rd_data)
  );

  assign wr_en = load_en && (state == ST_IDLE || state == ST_HALTED);
  assign rd_en = (state == ST_FETCH);

  // The fetched word is visible in the ISSUE cycle itself; instr_q keeps it afterwards.
  assign instruction = (state == ST_ISSUE) ? rd_data : instr_q;
  assign instr_valid = (state == ST_ISSUE);
  assign pc          = pc_q;
  assign busy        = is_busy(state);
  assign done        = (state == ST_HALTED);

  assign opcode   = instruction[INSTR_WIDTH-1 -: OPC_W];
  assign stop_hit = stop_q || stop;
  assign boundary = (state == ST_HOLD && cnt == 4'd1) ||
                    (state == ST_ISSUE && ISSUE_CYCLES == 2);

`ifdef SEQ_SINGLE_STEP_EN
  assign step_ok = !step_mode || step;
`else
  assign step_ok = 1'b1;
`endif

  // A pending stop ends the run even while waiting for a step.
  assign advance = boundary && (step_ok || stop_hit);

  always_comb begin
    adv_state = ST_FETCH;
    adv_pc    = pc_q + 1'b1;
    if (stop_hit) begin
      adv_state = ST_IDLE;
      adv_pc    = pc_q;
    end else if (opcode == OPC_HALT) begin
      adv_state = ST_HALTED;
      adv_pc    = pc_q;
    end else if (opcode == OPC_JMP) begin
      adv_pc    = instruction[ADDR_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      cnt     <= '0;
      stop_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state  <= ST_FETCH;
            pc_q   <= '0;
            stop_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          state <= ST_ISSUE;
          if (stop) stop_q <= 1'b1;
        end
        ST_ISSUE: begin
          instr_q <= rd_data;
          cnt     <= CNT_LOAD;
          if (stop) stop_q <= 1'b1;
          if (advance) begin
            state  <= adv_state;
            pc_q   <= adv_pc;
            stop_q <= 1'b0;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (stop) stop_q <= 1'b1;
          if (advance) begin
            state  <= adv_state;
            pc_q   <= adv_pc;
            stop_q <= 1'b0;
          end else if (!boundary) begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues expected issues,
// a negedge monitor pops and checks pc, word and cycle offset from start.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [19:0] load_data;
  logic        start;
  logic        stop;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        done;

  instr_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .stop       (stop),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  pc;
    logic [19:0] ins;
    int          rel;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   start_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue got pc %0h instr %0h at rel %0d", pc, instruction, cyc - start_cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_pc", 32'(pc), 32'(e.pc));
        chk("issue_instr", 32'(instruction), 32'(e.ins));
        chk("issue_cycle", 32'(cyc - start_cyc), 32'(e.rel));
      end
    end
  end

  task automatic push(input logic [4:0] p, input logic [19:0] w, input int rel);
    exp_t e;
    e.pc = p; e.ins = w; e.rel = rel;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [4:0] a, input logic [19:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic goto(input int rel);
    while (cyc < start_cyc + rel) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b1;

    // straight-line program ending in HALT
    load(5'd0, 20'h10001); load(5'd1, 20'h20002); load(5'd2, 20'hF0000);
    push(5'd0, 20'h10001, 2); push(5'd1, 20'h20002, 6); push(5'd2, 20'hF0000, 10);
    go();
    goto(5);
    chk("hold_through_fetch", 32'(instruction), 32'h10001);
    goto(12);
    chk("halt_not_early", 32'(done), 0);
    goto(13);
    chk("halt_done", 32'(done), 1);
    chk("halt_busy", 32'(busy), 0);
    goto(16);
    chk("halted_instr_held", 32'(instruction), 32'hF0000);

    // JMP, with the target write issued in the same cycle as start
    load(5'd0, 20'hE0005);
    push(5'd0, 20'hE0005, 2); push(5'd5, 20'hF0000, 6);
    load_en = 1'b1; load_addr = 5'd5; load_data = 20'hF0000;
    go();
    goto(9);
    chk("jmp_done", 32'(done), 1);
    chk("jmp_busy", 32'(busy), 0);

    // 32 non-halting words: pc wraps 31 -> 0, then stop
    for (int i = 0; i < 32; i++) load(5'(i), 20'h10000 | 20'(i));
    for (int i = 0; i < 32; i++) push(5'(i), 20'h10000 | 20'(i), 2 + 4 * i);
    push(5'd0, 20'h10000, 130);
    go();
    goto(131);
    pulse_stop();
    goto(133);
    chk("wrap_stop_busy", 32'(busy), 0);
    chk("wrap_stop_done", 32'(done), 0);
    goto(140);

    // stop during HOLD of pc=3
    for (int i = 0; i < 4; i++) push(5'(i), 20'h10000 | 20'(i), 2 + 4 * i);
    go();
    goto(15);
    pulse_stop();
    chk("stop_window_instr", 32'(instruction), 32'h10003);
    chk("stop_window_busy", 32'(busy), 1);
    goto(17);
    chk("stop_idle_busy", 32'(busy), 0);
    chk("stop_idle_done", 32'(done), 0);
    chk("stop_idle_instr", 32'(instruction), 32'h10003);
    goto(25);

    // write to addr 1 while busy must be ignored
    push(5'd0, 20'h10000, 2); push(5'd1, 20'h10001, 6);
    go();
    goto(3);
    load(5'd1, 20'hF0000);
    goto(7);
    pulse_stop();
    goto(9);
    chk("busy_write_stop", 32'(busy), 0);
    push(5'd0, 20'h10000, 2); push(5'd1, 20'h10001, 6);
    go();
    goto(7);
    pulse_stop();
    goto(9);

    // reset during HOLD; store survives
    push(5'd0, 20'h10000, 2); push(5'd1, 20'h10001, 6);
    go();
    goto(7);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_pc", 32'(pc), 0);
    chk("midrst_instr", 32'(instruction), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_valid", 32'(instr_valid), 0);
    rst = 1'b1;
    push(5'd0, 20'h10000, 2); push(5'd1, 20'h10001, 6);
    go();
    goto(7);
    pulse_stop();
    goto(9);

    // stop and HALT at the same boundary -> IDLE, not HALTED
    load(5'd0, 20'hF0000);
    push(5'd0, 20'hF0000, 2);
    go();
    goto(3);
    pulse_stop();
    goto(5);
    chk("stop_vs_halt_done", 32'(done), 0);
    chk("stop_vs_halt_busy", 32'(busy), 0);
    goto(10);

    chk("pending_issues", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
